interrupt_controller: RTL
=========================

Name: interrupt_controller

Overview:
- Sequences interrupt delivery to a single core: captures raw interrupt lines, applies per-line enables and fixed priority (line 0 highest), and drives IRQ/ID to the CPU.
- Tracks the acknowledge and end-of-interrupt (EOI) handshake so only one interrupt is in service at a time.
- Sits between peripheral interrupt sources and the core's trap logic, and owns the priority-encode function internally.

Parameters:
- N_IRQ, 4, number of interrupt lines (2..16).
- ID_W, 2, width of the interrupt ID; must equal ceil(log2(N_IRQ)).
- EDGE_MASK, 4'b1111, per-line trigger mode: 1 = rising-edge, 0 = level.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- interrupts  in  N_IRQ  raw request lines, synchronous to clk.
- en_wr  in  1  one-cycle pulse; loads en_data into the enable register.
- en_data  in  N_IRQ  new enable value.
- en_q  out  N_IRQ  current enable register.
- pending_q  out  N_IRQ  current pending register.
- IRQ  out  1  interrupt request to the core (registered).
- y  out  ID_W  ID of the requested or in-service line (registered).
- ack  in  1  core accepts the request in y; honoured only while IRQ=1.
- eoi  in  1  core signals end of service.
- eoi_id  in  ID_W  ID being retired.
- in_service  out  1  high from accepted ack until matching EOI.
- eoi_err  out  1  one-cycle pulse on an EOI with no matching in-service ID.

Behaviour:
- Reset (async assert, sync-free deassert): state=IDLE, pending=0, enable=0, prev_in=0, IRQ=0, y=0, in_service=0, eoi_err=0.
- Capture, evaluated every clock:
  - Edge line i: set pending[i] when interrupts[i]=1 and prev_in[i]=0. prev_in is registered interrupts.
  - Level line i: pending[i] = interrupts[i] each cycle; ack does not clear it, the source must deassert.
  - Edge set and ack-clear of the same bit in the same cycle: set wins, so the bit stays pending.
- Enables:
  - en_wr takes effect at the next edge.
  - Disabling a line does not clear its pending bit; re-enabling re-exposes it.
- Eligible set: E = pending & enable. Winner = lowest index set in E.
- FSM:
  - IDLE: if E≠0 → ASSERT; IRQ<=1, y<=winner. Otherwise IRQ=0 and y holds its last value.
  - ASSERT:
    - y re-evaluates to the current winner every cycle, so a higher-priority arrival before ack replaces y.
    - If E becomes 0 before ack (withdrawal or disable) → IDLE, IRQ<=0. No service occurs.
    - ack=1 → SERVICE; IRQ<=0, in_service<=1, y frozen to the acked ID, pending[y] cleared if that line is edge mode.
  - SERVICE:
    - No nesting: new pending bits accumulate but IRQ stays 0.
    - eoi=1 with eoi_id==y → IDLE, in_service<=0. A new IRQ can assert on the following edge.
    - eoi=1 with eoi_id≠y → eoi_err pulses for 1 cycle; state unchanged.
  - eoi in IDLE or ASSERT → eoi_err pulse; otherwise ignored.
  - ack in IDLE or SERVICE → ignored.
- Latency:
  - Edge-line rise on interrupts sampled at edge k sets pending at k; IRQ=1 after edge k+1.
  - ack sampled at edge m: IRQ=0 and in_service=1 after edge m.
  - Minimum EOI-to-next-IRQ is 1 cycle.
- Reset mid-operation: all state returns to reset values immediately. Pending edges are lost, and the enable register must be reprogrammed.
- Width rule: winner is encoded in ID_W bits; eoi_id compares all ID_W bits.

Test Plan:
- Reset then en_wr=1 with en_data=4'b1111. Pulse interrupts=4'b0100 (edge) for 1 cycle → pending_q=4'b0100 after 1 edge; IRQ=1, y=2'b10 after next edge; in_service=0.
- From the previous state, assert ack → IRQ=0, in_service=1, pending_q=0 same edge. Then eoi=1, eoi_id=2'b10 → in_service=0, state IDLE, eoi_err=0.
- Priority replacement: raise line 3 and wait for IRQ=1, y=2'b11. Before ack, raise line 1 → y=2'b01 next cycle. ack → pending_q=4'b1000. After EOI(01), IRQ reasserts with y=2'b11.
- Withdrawal and masking: pending line 2 with IRQ=1, then en_wr with en_data=4'b1011 → IRQ=0 next cycle, pending_q[2] stays 1. Re-enable with 4'b1111 → IRQ=1, y=2'b10.
- Error and set-wins:
  - In SERVICE for ID 0, eoi with eoi_id=2'b01 → eoi_err high for exactly 1 cycle, in_service stays 1.
  - A new rise on line 0 in the ack cycle → pending_q[0]=1 after ack.
- Level mode (EDGE_MASK=4'b1110): hold interrupts[0]=1 → pending stays set after ack. IRQ reasserts 1 cycle after EOI(00). Drop the line → pending_q[0]=0 next edge. Assert rst_n=0 mid-ASSERT → IRQ=0 and en_q=0 immediately.

Source files
------------

// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller for a single core.
// Captures edge/level requests and runs the ack/EOI handshake.
module interrupt_controller #(
  parameter int N_IRQ = 4,
  parameter int ID_W = 2,
  parameter logic [N_IRQ-1:0] EDGE_MASK = 4'b1111
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] interrupts,
  input  logic             en_wr,
  input  logic [N_IRQ-1:0] en_data,
  output logic [N_IRQ-1:0] en_q,
  output logic [N_IRQ-1:0] pending_q,
  output logic             IRQ,
  output logic [ID_W-1:0]  y,
  input  logic             ack,
  input  logic             eoi,
  input  logic [ID_W-1:0]  eoi_id,
  output logic             in_service,
  output logic             eoi_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_SERVICE
  } state_t;

  state_t           state;
  logic [N_IRQ-1:0] prev_in;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] elig;
  logic [N_IRQ-1:0] clr;
  logic [N_IRQ-1:0] pend_d;
  logic [ID_W-1:0]  winner;
  logic             take;
  logic             eoi_hit;

  assign rise    = interrupts & ~prev_in;
  assign elig    = pending_q & en_q;
  assign take    = (state == S_ASSERT) && ack;
  assign eoi_hit = eoi && (state == S_SERVICE)
                   && (eoi_id == y);

  // Ack clears the acked bit; a same-cycle edge set still wins.
  assign clr    = take ? (N_IRQ'(1) << y) : '0;
  assign pend_d = (EDGE_MASK & ((pending_q & ~clr) | rise))
                | (~EDGE_MASK & interrupts);

  // Lowest eligible index wins.
  always_comb begin
    winner = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) winner = ID_W'(i);
    end
  end

  // Capture, enable and edge-history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_in   <= '0;
      pending_q <= '0;
      en_q      <= '0;
    end else begin
      prev_in   <= interrupts;
      pending_q <= pend_d;
      if (en_wr) en_q <= en_data;
    end
  end

  // Delivery FSM with registered request, ID and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      IRQ        <= 1'b0;
      y          <= '0;
      in_service <= 1'b0;
      eoi_err    <= 1'b0;
    end else begin
      eoi_err <= eoi && !eoi_hit;
      unique case (state)
        S_IDLE: begin
          if (elig != '0) begin
            state <= S_ASSERT;
            IRQ   <= 1'b1;
            y     <= winner;
          end
        end
        S_ASSERT: begin
          if (ack) begin
            state      <= S_SERVICE;
            IRQ        <= 1'b0;
            in_service <= 1'b1;
          end else if (elig == '0) begin
            state <= S_IDLE;
            IRQ   <= 1'b0;
          end else begin
            y <= winner;
          end
        end
        S_SERVICE: begin
          if (eoi_hit) begin
            state      <= S_IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          IRQ        <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule
